// File: rtl/pwm_multi_counter_pkg.sv
`default_nettype none
// ============================================================================
// Package     : pwm_pkg
// Description : Shared constants for the PWM timebase (counting modes,
//               direction encoding, default geometry).
// Revision    : 1.0 - initial release
// ============================================================================
package pwm_pkg;

    // Counting modes
    localparam int MODE_EDGE   = 0;
    localparam int MODE_CENTER = 1;

    // Counter direction encoding
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Default geometry
    localparam int DEFAULT_WIDTH    = 8;
    localparam int DEFAULT_CHANNELS = 4;

endpackage
`default_nettype wire

// File: rtl/pwm_compare_channel.sv
`default_nettype none
// ============================================================================
// Module      : pwm_compare_channel
// Description : One PWM channel: pending/active duty shadow registers and a
//               registered comparator fed with the counter's next value, so
//               the output matches (CNTR < duty) in the same cycle as CNTR.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_compare_channel
    import pwm_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_capture,     // store i_duty into pending
    input  logic             i_apply_in,    // boundary load: i_duty goes active directly
    input  logic             i_apply_pend,  // boundary: pending duty goes active
    input  logic [WIDTH-1:0] i_duty,
    input  logic [WIDTH-1:0] i_cnt_next,    // counter value after this edge
    output logic             o_pwm
);

    logic [WIDTH-1:0] duty_pend_q, duty_pend_d;
    logic [WIDTH-1:0] duty_act_q,  duty_act_d;
    logic             pwm_q,       pwm_d;

    // Shadow register update and compare against the post-edge count/duty
    always_comb begin
        duty_pend_d = i_capture ? i_duty : duty_pend_q;
        duty_act_d  = duty_act_q;
        if (i_apply_in) begin
            duty_act_d = i_duty;
        end else if (i_apply_pend) begin
            duty_act_d = duty_pend_q;
        end
        pwm_d = (i_cnt_next < duty_act_d);
    end

    // Channel state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_pend_q <= '0;
            duty_act_q  <= '0;
            pwm_q       <= 1'b0;
        end else begin
            duty_pend_q <= duty_pend_d;
            duty_act_q  <= duty_act_d;
            pwm_q       <= pwm_d;
        end
    end

    assign o_pwm = pwm_q;

endmodule
`default_nettype wire

// File: rtl/pwm_multi_counter.sv
`default_nettype none
// ============================================================================
// Module      : pwm_multi_counter
// Description : Parametrised PWM timebase. WIDTH-bit period counter, edge- or
//               center-aligned, with CHANNELS double-buffered duty compare
//               channels. New period/duty values take effect only on the
//               edge that returns the counter to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_multi_counter
    import pwm_pkg::*;
#(
    parameter int               WIDTH        = DEFAULT_WIDTH,
    parameter int               CHANNELS     = DEFAULT_CHANNELS,
    parameter int               CENTER       = MODE_EDGE,
    parameter logic [WIDTH-1:0] RESET_PERIOD = {WIDTH{1'b1}}
) (
    input  logic                      CLoK,
    input  logic                      Reset,
    input  logic                      Enable,
    input  logic                      Load,
    input  logic [WIDTH-1:0]          Period,
    input  logic [CHANNELS*WIDTH-1:0] Duty,
    output logic [WIDTH-1:0]          CNTR,
    output logic [CHANNELS-1:0]       Pwm_Out,
    output logic                      Wrap,
    output logic                      Load_Ack
);

    localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

    logic [WIDTH-1:0] cnt_q,         cnt_d;
    logic             dir_q,         dir_d;
    logic [WIDTH-1:0] period_act_q,  period_act_d;
    logic [WIDTH-1:0] period_pend_q, period_pend_d;
    logic             pend_q,        pend_d;
    logic             wrap_q,        wrap_d;
    logic             ack_q,         ack_d;

    logic [WIDTH-1:0] w_cnt_step;
    logic             w_dir_step;
    logic             w_boundary;
    logic             w_capture;
    logic             w_apply_in;
    logic             w_apply_pend;

    // Next count/direction assuming the counter advances this cycle
    always_comb begin
        w_cnt_step = cnt_q;
        w_dir_step = dir_q;
        if (CENTER == MODE_CENTER) begin
            if (dir_q == DIR_UP) begin
                if (cnt_q < period_act_q) begin
                    w_cnt_step = cnt_q + c_one;
                    w_dir_step = ((cnt_q + c_one) == period_act_q) ? DIR_DOWN : DIR_UP;
                end else begin
                    // Zero period: pinned at 0, every step is a boundary
                    w_cnt_step = '0;
                    w_dir_step = DIR_UP;
                end
            end else begin
                if (cnt_q <= c_one) begin
                    w_cnt_step = '0;
                    w_dir_step = DIR_UP;
                end else begin
                    w_cnt_step = cnt_q - c_one;
                    w_dir_step = DIR_DOWN;
                end
            end
        end else begin
            // Natural rollover covers the all-ones period
            w_cnt_step = (cnt_q == period_act_q) ? '0 : cnt_q + c_one;
            w_dir_step = DIR_UP;
        end
    end

    // Boundary detect and shadow-register control. The step only yields 0
    // when a period ends, so a zero step while enabled marks the boundary.
    always_comb begin
        w_boundary   = Enable && (w_cnt_step == '0);
        w_capture    = Load && !w_boundary;
        w_apply_in   = Load && w_boundary;
        w_apply_pend = !Load && w_boundary && pend_q;

        cnt_d = Enable ? w_cnt_step : cnt_q;
        dir_d = Enable ? w_dir_step : dir_q;

        period_pend_d = w_capture ? Period : period_pend_q;
        period_act_d  = period_act_q;
        if (w_apply_in) begin
            period_act_d = Period;
        end else if (w_apply_pend) begin
            period_act_d = period_pend_q;
        end

        pend_d = pend_q;
        if (w_capture) begin
            pend_d = 1'b1;
        end else if (w_boundary) begin
            pend_d = 1'b0;
        end

        wrap_d = w_boundary;
        ack_d  = w_apply_in || w_apply_pend;
    end

    // Timebase state registers
    always_ff @(posedge CLoK or posedge Reset) begin
        if (Reset) begin
            cnt_q         <= '0;
            dir_q         <= DIR_UP;
            period_act_q  <= RESET_PERIOD;
            period_pend_q <= '0;
            pend_q        <= 1'b0;
            wrap_q        <= 1'b0;
            ack_q         <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            dir_q         <= dir_d;
            period_act_q  <= period_act_d;
            period_pend_q <= period_pend_d;
            pend_q        <= pend_d;
            wrap_q        <= wrap_d;
            ack_q         <= ack_d;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        pwm_compare_channel #(
            .WIDTH (WIDTH)
        ) u_ch (
            .clk          (CLoK),
            .rst          (Reset),
            .i_capture    (w_capture),
            .i_apply_in   (w_apply_in),
            .i_apply_pend (w_apply_pend),
            .i_duty       (Duty[i*WIDTH +: WIDTH]),
            .i_cnt_next   (cnt_d),
            .o_pwm        (Pwm_Out[i])
        );
    end

    assign CNTR     = cnt_q;
    assign Wrap     = wrap_q;
    assign Load_Ack = ack_q;

endmodule
`default_nettype wire
